// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: decoded operands/control captured from decode,
// held on stall, replaced by a bubble on flush or when decode is empty.
// Ports:
//   clk, reset          : clock; async active-high reset
//   stall, flush        : hazard-unit hold and bubble-insert requests
//   id_*                : decode-stage fields (valid, pc, operands, control)
//   ex_*                : registered copies presented to execute
//   stall_cnt,
//   bubble_cnt          : event counters, present only with ID_EX_PERF_CNT_EN
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [3:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [1:0]        ex_alu_op,
  output logic [3:0]        ex_funct,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [1:0]        alu_op;
    logic [3:0]        funct;
    logic              alu_src;
    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
  } ex_t;

  ex_t  r_ex;
  ex_t  w_load;
  logic w_bubble;
  logic w_hold;

  // x0 is hardwired: never let a write to it reach writeback
  always_comb begin
    w_load            = '0;
    w_load.valid      = 1'b1;
    w_load.pc         = id_pc;
    w_load.rs1_data   = id_rs1_data;
    w_load.rs2_data   = id_rs2_data;
    w_load.imm        = id_imm;
    w_load.rs1        = id_rs1;
    w_load.rs2        = id_rs2;
    w_load.rd         = id_rd;
    w_load.alu_op     = id_alu_op;
    w_load.funct      = id_funct;
    w_load.alu_src    = id_alu_src;
    w_load.branch     = id_branch;
    w_load.mem_read   = id_mem_read;
    w_load.mem_write  = id_mem_write;
    w_load.mem_to_reg = id_mem_to_reg;
    w_load.reg_write  = id_reg_write & (id_rd != '0);
  end

  // flush beats stall; an empty decode slot becomes a bubble
  assign w_hold   = stall & ~flush;
  assign w_bubble = flush | (~stall & ~id_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex <= '0;
    end else if (w_bubble) begin
      r_ex <= '0;
    end else if (!w_hold) begin
      r_ex <= w_load;
    end
  end

  assign ex_valid      = r_ex.valid;
  assign ex_pc         = r_ex.pc;
  assign ex_rs1_data   = r_ex.rs1_data;
  assign ex_rs2_data   = r_ex.rs2_data;
  assign ex_imm        = r_ex.imm;
  assign ex_rs1        = r_ex.rs1;
  assign ex_rs2        = r_ex.rs2;
  assign ex_rd         = r_ex.rd;
  assign ex_alu_op     = r_ex.alu_op;
  assign ex_funct      = r_ex.funct;
  assign ex_alu_src    = r_ex.alu_src;
  assign ex_branch     = r_ex.branch;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_mem_to_reg = r_ex.mem_to_reg;
  assign ex_reg_write  = r_ex.reg_write;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_hold)   r_stall_cnt  <= r_stall_cnt + 1'b1;
      if (w_bubble) r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core.
- Captures decoded operands and control from the decode stage.
- Presents them to the execute stage for one cycle, including the 2-bit ALU op and the 4-bit funct ({instr[30], funct3}) consumed by the ALU control decoder.
- Supports hazard-unit stall (hold) and branch/hazard flush (bubble insert).

Parameters:
- DATA_W, 32, width of PC, register operands and immediate
- REG_AW, 5, register index width
- CNT_W, 32, width of the optional event counters

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hold current contents (hazard unit load-use stall)
- flush  in  1  replace contents with a bubble (taken branch / hazard)
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  DATA_W  instruction PC
- id_rs1_data, id_rs2_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices
- id_alu_op  in  2  00 add (ld/st), 01 sub (branch), 10 R-type decode
- id_funct  in  4  {instr[30], funct3}
- id_alu_src, id_branch, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write  in  1 each  main-control bits
- ex_valid  out  1  execute stage holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  DATA_W  registered copies
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered copies
- ex_alu_op  out  2
- ex_funct  out  4
- ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1 each

Behaviour:
- All outputs registered; latency exactly 1 cycle from id_* to ex_*.
- Reset (async, active-high): every output goes to 0 immediately, and stays 0 while reset is high. ex_alu_op=00 and ex_funct=0000 (harmless add of a bubble).
- Update priority at each rising edge, reset deasserted:
  - flush=1: load bubble.
  - else stall=1: hold all outputs unchanged.
  - else id_valid=0: load bubble.
  - else: load id_* fields.
- Bubble: ex_valid=0; all control outputs 0 (alu_op=00, funct=0000, reg_write=mem_read=mem_write=branch=mem_to_reg=alu_src=0); data/index outputs 0.
- flush and stall both high in the same cycle: flush wins; a bubble is loaded.
- Register-0 guard: on load, ex_reg_write = id_reg_write AND (id_rd != 0). All other fields are copied verbatim.
- Multi-cycle stall: contents held indefinitely. First edge after stall drops loads the current id_* values.
- Reset asserted mid-stall or mid-flush: clears immediately. First post-reset edge follows the normal priority rules.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds two output ports, stall_cnt [CNT_W] and bubble_cnt [CNT_W], both reset to 0.
  - stall_cnt increments on each edge where stall=1 and flush=0.
  - bubble_cnt increments on each edge where a bubble is loaded (flush=1, or stall=0 with id_valid=0).
  - Both wrap modulo 2^CNT_W.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then release; drive id_valid=1, id_alu_op=10, id_funct=1000, id_rd=5, id_reg_write=1, id_rs1_data=0x11 -> next edge ex_valid=1, ex_alu_op=10, ex_funct=1000, ex_rd=5, ex_reg_write=1, ex_rs1_data=0x11.
- Load pc=0x40, then stall=1 for 3 cycles while id_pc changes to 0x44 -> ex_pc stays 0x40 for 3 edges. Stall drop -> ex_pc=0x44 next edge.
- flush=1 and stall=1 together with id_valid=1, id_mem_write=1 -> next edge ex_valid=0, ex_mem_write=0, ex_alu_op=00, all data outputs 0.
- id_rd=0, id_reg_write=1, id_valid=1 -> ex_reg_write=0, ex_valid=1.
- Assert reset between clock edges while ex_valid=1 -> outputs 0 before the next edge. With ID_EX_PERF_CNT_EN defined, stall_cnt and bubble_cnt also go to 0.
- With ID_EX_PERF_CNT_EN defined: 2 stall cycles, 1 flush, 1 id_valid=0 cycle -> stall_cnt=2, bubble_cnt=2.
